iter_shifter: RTL and testbench
===============================

// Module: iter_shifter
// PURPOSE
//   Parametrised multi-cycle shift/rotate unit for the ALU datapath; successor to the
//   single-step bidirectional shift register. Accepts an operand, shift amount and op on a
//   start pulse, shifts STEP bits per clock, pulses done with the result. Supports logical,
//   arithmetic and rotate modes with synchronous flush. Sits beside the ALU for SLL/SRL/SRA.
// PARAMETERS
//   WIDTH    32                 operand/result width in bits (>=2)
//   SHAMT_W  $clog2(WIDTH)      shift-amount width; amounts are 0..WIDTH-1
//   STEP     1                  max bits shifted per cycle; power of 2, 1..WIDTH
// PORTS
//   clk     in   1        clock, all state updates on rising edge
//   rst_n   in   1        asynchronous, active-low reset
//   start   in   1        request; sampled only when not busy
//   flush   in   1        synchronous abort of an operation in flight
//   op      in   3        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
//   d       in   WIDTH    operand, sampled with start
//   shamt   in   SHAMT_W  shift amount, sampled with start
//   busy    out  1        1 while in SHIFT
//   done    out  1        one-cycle result-valid pulse
//   q       out  WIDTH    result; holds until next completion
// BEHAVIOUR
//   - Reset (rst_n low, async): state IDLE, q=0, done=0, busy=0, counter=0. Reset mid-op
//     drops the op; no done is produced.
//   - FSM states IDLE, SHIFT, DONE. start accepted in IDLE or DONE (back-to-back allowed);
//     ignored in SHIFT. On acceptance: latch op, work<=d, cnt<=shamt; sign bit := d[WIDTH-1].
//     cnt==0 -> DONE (q<=d); else -> SHIFT.
//   - SHIFT: each edge shift work by k=min(STEP,cnt) in latched mode, cnt<=cnt-k. When cnt
//     reaches 0 on that edge -> DONE with q<=shifted value.
//   - DONE: done=1 for exactly one cycle, then IDLE unless new start accepted.
//   - Latency: start sampled in cycle c -> done high in cycle c+ceil(shamt/STEP)+1.
//   - Fill: SLL/SRL zero fill; SRA fills with latched sign bit; ROL/ROR wrap bits around,
//     i.e. result equals rotate by shamt mod WIDTH.
//   - Reserved op: treated as shamt=0; q<=d, done after 1 cycle.
//   - flush=1 in SHIFT: -> IDLE next edge, no done, q unchanged. flush has priority over
//     start in the same cycle. flush in IDLE/DONE: no effect on q; done still ends normally.
//   - op/d/shamt changes while busy have no effect.
//   - q only updated on entry to DONE or reset; never shows partial results.
// STRUCTURE
//   - Shared header shifter_defs.vh: op encodings (OP_SLL..OP_ROR), state encodings
//     (ST_IDLE, ST_SHIFT, ST_DONE); also used by ALU decode.
//   - One sub-module: shift_step (combinational: work, op, sign, k in 0..STEP -> shifted
//     work). Top holds FSM, counter, work/q registers.
// TESTING
//   1. WIDTH=32,STEP=1: SLL d=0x0000_0001 shamt=4 -> busy 4 cycles, done cycle c+5, q=0x10.
//   2. SRA d=0x8000_0000 shamt=31 STEP=4 -> done c+9, q=0xFFFF_FFFF; SRL same -> q=0x1.
//   3. ROR d=0x0000_00F1 shamt=4 STEP=2 -> q=0x1000_000F; ROL shamt=0 -> q=d at c+1.
//   4. flush in 2nd SHIFT cycle of SLL shamt=8 -> no done, busy low next cycle, q keeps prior.
//   5. rst_n low mid-SHIFT -> q=0, busy=0, done=0 immediately (async), IDLE on release.
//   6. start held in DONE cycle with new op -> second done after expected latency; start
//      during SHIFT ignored; op=111 -> q=d, done at c+1.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shift/rotate unit.
// Op and state encodings are also consumed by ALU decode.
package iter_shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift_op(
    input logic [2:0] op
  );
    return op <= 3'(OP_ROR);
  endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/result bundle between the ALU issue logic
// and the iterative shifter.
interface iter_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);

  logic               start;
  logic               flush;
  logic [2:0]         op;
  logic [WIDTH-1:0]   d;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   q;

  modport master (
    output start,
    output flush,
    output op,
    output d,
    output shamt,
    input  busy,
    input  done,
    input  q
  );

  modport slave (
    input  start,
    input  flush,
    input  op,
    input  d,
    input  shamt,
    output busy,
    output done,
    output q
  );

endinterface

// File: rtl/iter_shifter_shift_step.sv
// One shift/rotate step of k bits (0..STEP) on the
// working value; purely combinational.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_work,
  input  op_e              i_op,
  input  logic             i_sign,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_work
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [31:0]      w_kc;
  logic [WIDTH-1:0] w_fill;

  assign w_kc = 32'(WIDTH) - 32'(i_k);

  // Vacated high bits after an arithmetic right shift
  assign w_fill = i_sign ? ~(ONES >> i_k) : '0;

  always_comb begin
    o_work = i_work;
    unique case (1'b1)
      (i_op == OP_SLL): o_work = i_work << i_k;
      (i_op == OP_SRL): o_work = i_work >> i_k;
      (i_op == OP_SRA): o_work = (i_work >> i_k) | w_fill;
      (i_op == OP_ROL):
        o_work = (i_work << i_k) | (i_work >> w_kc);
      (i_op == OP_ROR):
        o_work = (i_work >> i_k) | (i_work << w_kc);
      default: o_work = i_work;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: up to STEP bits per
// clock, one-cycle done pulse with the final result.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  iter_shifter_if.slave bus
);

  localparam int KW = $clog2(STEP + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_q;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_sign;

  logic [WIDTH-1:0]   w_shifted;
  logic [SHAMT_W-1:0] w_cnt_nxt;
  logic [SHAMT_W-1:0] w_shamt_in;
  logic [KW-1:0]      w_k;
  logic               w_accept;
  logic               w_fin;
  logic               w_step;

  // k = min(STEP, cnt); the remainder always fits in KW bits
  assign w_k = (32'(r_cnt) >= 32'(STEP)) ?
               KW'(STEP) : KW'(r_cnt);

  assign w_cnt_nxt  = r_cnt - SHAMT_W'(w_k);
  assign w_fin      = (w_cnt_nxt == '0);
  assign w_shamt_in = is_shift_op(bus.op) ?
                      bus.shamt : '0;
  assign w_accept   = bus.start &&
                      (r_state != ST_SHIFT);
  assign w_step     = (r_state == ST_SHIFT) &&
                      !bus.flush;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .i_work (r_work),
    .i_op   (r_op),
    .i_sign (r_sign),
    .i_k    (w_k),
    .o_work (w_shifted)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (!w_accept)
          w_state_nxt = ST_IDLE;
        else if (w_shamt_in == '0)
          w_state_nxt = ST_DONE;
        else
          w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.flush)
          w_state_nxt = ST_IDLE;
        else if (w_fin)
          w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SLL;
      r_work  <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= op_e'(bus.op);
        r_work <= bus.d;
        r_cnt  <= w_shamt_in;
        r_sign <= bus.d[WIDTH-1];
        if (w_shamt_in == '0)
          r_q <= bus.d;
      end else if (w_step) begin
        r_work <= w_shifted;
        r_cnt  <= w_cnt_nxt;
        if (w_fin)
          r_q <= w_shifted;
      end
    end
  end

  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);
  assign bus.q    = r_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench: three shifters (STEP 1, 2, 4) driven
// in lockstep, results checked against hand values.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] d;
  logic [4:0]  shamt;

  always #5 clk = ~clk;

  iter_shifter_if #(.WIDTH(32)) if1 ();
  iter_shifter_if #(.WIDTH(32)) if2 ();
  iter_shifter_if #(.WIDTH(32)) if4 ();

  assign if1.start = start;
  assign if1.flush = flush;
  assign if1.op    = op;
  assign if1.d     = d;
  assign if1.shamt = shamt;
  assign if2.start = start;
  assign if2.flush = flush;
  assign if2.op    = op;
  assign if2.d     = d;
  assign if2.shamt = shamt;
  assign if4.start = start;
  assign if4.flush = flush;
  assign if4.op    = op;
  assign if4.d     = d;
  assign if4.shamt = shamt;

  iter_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );
  iter_shifter #(.WIDTH(32), .STEP(2)) u_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );
  iter_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  logic [2:0]  w_done;
  logic [2:0]  w_busy;
  logic [31:0] w_q [3];

  assign w_done = {if4.done, if2.done, if1.done};
  assign w_busy = {if4.busy, if2.busy, if1.busy};
  assign w_q[0] = if1.q;
  assign w_q[1] = if2.q;
  assign w_q[2] = if4.q;

  int steps [3] = '{1, 2, 4};
  int checks = 0;
  int errors = 0;

  int          first_k [3];
  int          nbusy [3];
  int          ndone [3];
  logic [31:0] first_q [3];
  int          inj_k = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Watch n cycles after a start; k=1 is the first
  // negedge after the accepting edge.
  task automatic observe(input int n);
    for (int i = 0; i < 3; i++) begin
      first_k[i] = -1;
      first_q[i] = '0;
      nbusy[i]   = 0;
      ndone[i]   = 0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (w_busy[i]) nbusy[i]++;
        if (w_done[i]) begin
          ndone[i]++;
          if (first_k[i] < 0) begin
            first_k[i] = k;
            first_q[i] = w_q[i];
          end
        end
      end
      if (k == 1) start = 1'b0;
      if (inj_k != 0 && k == inj_k) begin
        start = 1'b1;
        op    = 3'b000;
        d     = 32'h0000_FFFF;
        shamt = 5'd0;
      end
      if (inj_k != 0 && k == inj_k + 1)
        start = 1'b0;
    end
  endtask

  task automatic check_run(
    input string       tag,
    input int          sh,
    input logic [31:0] eq
  );
    int lat;
    for (int i = 0; i < 3; i++) begin
      lat = (sh + steps[i] - 1) / steps[i] + 1;
      chk($sformatf("%s_s%0d_lat", tag, steps[i]),
          32'(first_k[i]), 32'(lat));
      chk($sformatf("%s_s%0d_q", tag, steps[i]),
          first_q[i], eq);
      chk($sformatf("%s_s%0d_ndone", tag, steps[i]),
          32'(ndone[i]), 32'd1);
      chk($sformatf("%s_s%0d_busy", tag, steps[i]),
          32'(nbusy[i]), 32'(lat - 1));
    end
  endtask

  task automatic vec(
    input string       tag,
    input logic [2:0]  o,
    input logic [31:0] dd,
    input logic [4:0]  sh,
    input logic [31:0] eq,
    input bit          rsv
  );
    @(negedge clk);
    start = 1'b1;
    op    = o;
    d     = dd;
    shamt = sh;
    observe(40);
    check_run(tag, rsv ? 0 : int'(sh), eq);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    d     = '0;
    shamt = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_q_%0d", i), w_q[i], 32'h0);
    end
    chk("rst_busy", 32'(w_busy), 32'h0);
    chk("rst_done", 32'(w_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("sll4",  3'b000, 32'h0000_0001, 5'd4,
        32'h0000_0010, 1'b0);
    vec("sra31", 3'b010, 32'h8000_0000, 5'd31,
        32'hFFFF_FFFF, 1'b0);
    vec("srl31", 3'b001, 32'h8000_0000, 5'd31,
        32'h0000_0001, 1'b0);
    vec("ror4",  3'b100, 32'h0000_00F1, 5'd4,
        32'h1000_000F, 1'b0);
    vec("rol0",  3'b011, 32'h0000_00F1, 5'd0,
        32'h0000_00F1, 1'b0);
    vec("rsv",   3'b111, 32'h1234_5678, 5'd5,
        32'h1234_5678, 1'b1);
    vec("rol1",  3'b011, 32'h8000_0001, 5'd1,
        32'h0000_0003, 1'b0);
    vec("sra4p", 3'b010, 32'h7000_0000, 5'd4,
        32'h0700_0000, 1'b0);
    vec("sra3n", 3'b010, 32'hF000_0000, 5'd3,
        32'hFE00_0000, 1'b0);
    vec("sll31", 3'b000, 32'hFFFF_FFFF, 5'd31,
        32'h8000_0000, 1'b0);
    vec("ror31", 3'b100, 32'h0000_0001, 5'd31,
        32'h0000_0002, 1'b0);

    // Flush in the second SHIFT cycle of SLL by 8
    @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    d     = 32'h0000_0001;
    shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("fl_busy_pre", 32'(w_busy), 32'h7);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", 32'(w_busy), 32'h0);
    chk("fl_done", 32'(w_done), 32'h0);
    observe(20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fl_nd_%0d", i),
          32'(ndone[i]), 32'd0);
      chk($sformatf("fl_q_%0d", i),
          w_q[i], 32'h0000_0002);
    end

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    d     = 32'h0000_0001;
    shamt = 5'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_busy_pre", 32'(w_busy), 32'h7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(w_busy), 32'h0);
    chk("ar_done", 32'(w_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ar_q_%0d", i), w_q[i], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(30);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ar_nd_%0d", i),
          32'(ndone[i]), 32'd0);
      chk($sformatf("ar_nb_%0d", i),
          32'(nbusy[i]), 32'd0);
    end

    // Back-to-back start in DONE, then start in SHIFT
    @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    d     = 32'h0000_0003;
    shamt = 5'd0;
    @(negedge clk);
    chk("b2b_done1", 32'(w_done), 32'h7);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_q1_%0d", i),
          w_q[i], 32'h0000_0003);
    end
    op    = 3'b011;
    d     = 32'h8000_0000;
    shamt = 5'd4;
    inj_k = 1;
    observe(40);
    inj_k = 0;
    check_run("b2b", 4, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
